baud_rate_gen_frac: RTL



---
 rtl/spart_pkg.sv | 14 +
 rtl/frac_accum.sv | 42 ++++
 rtl/baud_rate_gen_frac.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/spart_pkg.sv
// Shared widths and types for the fractional SPART baud generator.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package spart_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_DIV_W  = 16;
  localparam int DEF_FRAC_W = 4;
  localparam int DEF_OVS    = 16;

  typedef logic [DEF_DIV_W-1:0]  div_t;
  typedef logic [DEF_FRAC_W-1:0] frac_t;

endpackage

// File: rtl/frac_accum.sv
// Fractional phase accumulator; carry-out asks the divider for one extra cycle.
// Latency: carry is combinational from the current acc and frac; acc updates on the next edge.
// Backpressure: none; clr has priority over step.
module frac_accum
  import spart_pkg::*;
#(
  parameter int FRAC_W = DEF_FRAC_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              step,
  input  logic [FRAC_W-1:0] frac,
  output logic              carry
);

  logic [FRAC_W-1:0] acc_q;
  logic [FRAC_W-1:0] acc_d;
  logic [FRAC_W:0]   sum;

  // Next accumulator value and the carry the divider uses to stretch the reload.
  always_comb begin
    sum   = {1'b0, acc_q} + {1'b0, frac};
    carry = sum[FRAC_W];
    acc_d = acc_q;
    if (clr) begin
      acc_d = '0;
    end else if (step) begin
      acc_d = sum[FRAC_W-1:0];
    end
  end

  // Accumulator register, wraps modulo 2^FRAC_W.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/baud_rate_gen_frac.sv
// Fractional baud generator: oversample tick, RX bit-centre and TX bit-boundary strobes.
// Latency: first en arrives div cycles after the committing edge; all outputs are registered.
// Backpressure: none; host writes always accepted, a commit or rx_resync restarts the phase.
module baud_rate_gen_frac
  import spart_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DIV_W  = DEF_DIV_W,
  parameter int FRAC_W = DEF_FRAC_W,
  parameter int OVS    = DEF_OVS
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sel_low,
  input  logic              sel_high,
  input  logic              sel_frac,
  input  logic [DATA_W-1:0] data,
  input  logic              rx_resync,
  output logic              en,
  output logic              mid_tick,
  output logic              bit_tick,
  output logic              div_active
);

  localparam int OVS_W = $clog2(OVS);
  localparam logic [OVS_W-1:0] OVS_LAST = OVS_W'(OVS - 1);
  localparam logic [OVS_W-1:0] OVS_MID  = OVS_W'(OVS / 2 - 1);
  localparam logic [OVS_W-1:0] OVS_ONE  = OVS_W'(1);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

  logic [DATA_W-1:0] shadow_low_q, shadow_low_d;
  logic [FRAC_W-1:0] shadow_frac_q, shadow_frac_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [FRAC_W-1:0] frac_q, frac_d;
  logic [DIV_W-1:0]  cnt_q, cnt_d;
  logic [OVS_W-1:0]  ovs_q, ovs_d;
  logic              en_q, en_d;
  logic              mid_q, mid_d;
  logic              bit_q, bit_d;
  logic              active_q, active_d;

  logic [DIV_W-1:0]  commit_div;
  logic [FRAC_W-1:0] commit_frac;
  logic              acc_clr;
  logic              acc_step;
  logic              acc_carry;

  // A one-byte divisor is written whole by sel_high; a two-byte one takes its
  // low byte from the shadow, or straight from data when sel_low coincides.
  if (DIV_W == DATA_W) begin : g_one_byte
    assign commit_div   = data;
    assign shadow_low_d = shadow_low_q;
  end else begin : g_two_byte
    assign commit_div   = {data, sel_low ? data : shadow_low_q};
    assign shadow_low_d = sel_low ? data : shadow_low_q;
  end

  // Fractional shadow; a sel_frac in the commit cycle is committed directly.
  always_comb begin
    shadow_frac_d = sel_frac ? data[FRAC_W-1:0] : shadow_frac_q;
    commit_frac   = shadow_frac_d;
  end

  // Divider, OVS counter and pulse generation; commit beats resync beats ticking.
  always_comb begin
    div_d    = div_q;
    frac_d   = frac_q;
    cnt_d    = cnt_q;
    ovs_d    = ovs_q;
    en_d     = 1'b0;
    mid_d    = 1'b0;
    bit_d    = 1'b0;
    active_d = active_q;
    acc_clr  = 1'b0;
    acc_step = 1'b0;
    if (sel_high) begin
      // Atomic commit: partial period discarded, phase restarted.
      div_d    = commit_div;
      frac_d   = commit_frac;
      active_d = (commit_div != '0);
      cnt_d    = (commit_div == '0) ? '0 : commit_div - DIV_ONE;
      ovs_d    = '0;
      acc_clr  = 1'b1;
    end else if (div_q == '0) begin
      // Stopped: counters parked at zero, resync ignored.
      cnt_d   = '0;
      ovs_d   = '0;
      acc_clr = 1'b1;
    end else if (rx_resync) begin
      // Start-bit edge: realign so the centre strobe lands OVS/2 ticks later.
      cnt_d   = div_q - DIV_ONE;
      ovs_d   = '0;
      acc_clr = 1'b1;
    end else if (cnt_q == '0) begin
      en_d     = 1'b1;
      mid_d    = (ovs_q == OVS_MID);
      bit_d    = (ovs_q == OVS_LAST);
      ovs_d    = ovs_q + OVS_ONE;
      acc_step = 1'b1;
      cnt_d    = acc_carry ? div_q : div_q - DIV_ONE;
    end else begin
      cnt_d = cnt_q - DIV_ONE;
    end
  end

  frac_accum #(
    .FRAC_W (FRAC_W)
  ) u_frac_accum (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (acc_clr),
    .step  (acc_step),
    .frac  (frac_q),
    .carry (acc_carry)
  );

  // State and registered outputs; reset aborts any period in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shadow_low_q  <= '0;
      shadow_frac_q <= '0;
      div_q         <= '0;
      frac_q        <= '0;
      cnt_q         <= '0;
      ovs_q         <= '0;
      en_q          <= 1'b0;
      mid_q         <= 1'b0;
      bit_q         <= 1'b0;
      active_q      <= 1'b0;
    end else begin
      shadow_low_q  <= shadow_low_d;
      shadow_frac_q <= shadow_frac_d;
      div_q         <= div_d;
      frac_q        <= frac_d;
      cnt_q         <= cnt_d;
      ovs_q         <= ovs_d;
      en_q          <= en_d;
      mid_q         <= mid_d;
      bit_q         <= bit_d;
      active_q      <= active_d;
    end
  end

  assign en         = en_q;
  assign mid_tick   = mid_q;
  assign bit_tick   = bit_q;
  assign div_active = active_q;

endmodule
